// File: rtl/display_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with per-frame snapshot and anode guard.
// Optional alarm blink enabled by defining DISPLAY_BLINK_EN.
module display_scan_driver #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned GUARD       = 16,
  parameter int unsigned BLINK_TICKS = 500,
  parameter int unsigned LZB         = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [3:0] h1_i,
  input  logic [3:0] h0_i,
  input  logic [3:0] m1_i,
  input  logic [3:0] m0_i,
  input  logic [3:0] s1_i,
  input  logic [3:0] s0_i,
  input  logic       alarm_i,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n,
  output logic       frame_o
);

  localparam int unsigned   CntW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0][3:0]  snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic [5:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;
  logic             tick, wrap, blink_off;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] slot_sel(input logic [5:0][3:0] s, input logic [2:0] i);
    logic [3:0] d;
    case (i)
      3'd0:    d = s[0];
      3'd1:    d = s[1];
      3'd2:    d = s[2];
      3'd3:    d = s[3];
      3'd4:    d = s[4];
      3'd5:    d = s[5];
      default: d = 4'h0;
    endcase
    return d;
  endfunction

  assign tick = (cnt_q == CntMax);
  assign wrap = tick && (idx_q == 3'd5);

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned      BlinkW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_TICKS - 1);

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!alarm_i) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_off = ~blink_on_d;
`else
  logic unused_alarm;
  assign unused_alarm = alarm_i ^ (BLINK_TICKS == 0);
  assign blink_off    = 1'b0;
`endif

  // Outputs are registered from next-state values so an_n/dp_n track the current cnt/idx.
  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    snap_d  = wrap ? {h1_i, h0_i, m1_i, m0_i, s1_i, s0_i} : snap_q;
    seg_d   = tick ? seg_decode(slot_sel(snap_d, idx_d)) : seg_q;
    frame_d = wrap;
    if ((cnt_d < GuardCnt) || blink_off ||
        ((LZB != 0) && (idx_d == 3'd5) && (snap_d[5] == 4'h0))) begin
      an_d = 6'h3F;
    end else begin
      an_d = ~(6'b000001 << idx_d);
    end
    dp_d = an_d[2] & an_d[4];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      snap_q  <= '0;
      seg_q   <= 7'h7F;
      an_q    <= 6'h3F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign seg_n   = seg_q;
  assign an_n    = an_q;
  assign dp_n    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed self-checking bench for display_scan_driver (SCAN_DIV=8, GUARD=2, BLINK_TICKS=4).
module tb_display_scan_driver;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [3:0] h1_i, h0_i, m1_i, m0_i, s1_i, s0_i;
  logic       alarm_i;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;
  logic       frame_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_frames;

  display_scan_driver #(
    .SCAN_DIV   (8),
    .GUARD      (2),
    .BLINK_TICKS(4),
    .LZB        (1)
  ) u_dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .h1_i         (h1_i),
    .h0_i         (h0_i),
    .m1_i         (m1_i),
    .m0_i         (m0_i),
    .s1_i         (s1_i),
    .s0_i         (s0_i),
    .alarm_i      (alarm_i),
    .seg_n        (seg_n),
    .dp_n         (dp_n),
    .an_n         (an_n),
    .frame_o      (frame_o)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance to 1 time unit after the k-th rising edge since reset release.
  task automatic adv_to(input int k);
    while (cyc < k) begin
      @(posedge clk_clk);
      cyc++;
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg"},   8'(seg_n),   8'h7F);
    check({tag, "_an"},    8'(an_n),    8'h3F);
    check({tag, "_dp"},    8'(dp_n),    8'h01);
    check({tag, "_frame"}, 8'(frame_o), 8'h00);
  endtask

  initial begin
    reset_reset_n = 1'b1;
    alarm_i = 1'b0;
    {h1_i, h0_i, m1_i, m0_i, s1_i, s0_i} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    #1 reset_reset_n = 1'b0;
    repeat (5) @(posedge clk_clk);
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    cyc = 0;

    // First frame: snapshot is all zeros.
    adv_to(1);  check("k1_an", 8'(an_n), 8'h3F); check("k1_seg", 8'(seg_n), 8'h7F);
    adv_to(2);  check("k2_an", 8'(an_n), 8'h3E); check("k2_dp", 8'(dp_n), 8'h01);
    adv_to(8);  check("tick1_an", 8'(an_n), 8'h3F); check("tick1_seg", 8'(seg_n), 8'h40);
    adv_to(10); check("slot1_an", 8'(an_n), 8'h3D);
    adv_to(18); check("slot2_an", 8'(an_n), 8'h3B); check("slot2_dp", 8'(dp_n), 8'h00);
    adv_to(26); check("slot3_an", 8'(an_n), 8'h37); check("slot3_dp", 8'(dp_n), 8'h01);
    adv_to(42); check("lzb0_an", 8'(an_n), 8'h3F);
    adv_to(47); check("pre_frame", 8'(frame_o), 8'h00);
    adv_to(48); check("frame1", 8'(frame_o), 8'h01); check("f1_seg", 8'(seg_n), 8'h02);
    check("f1_guard_an", 8'(an_n), 8'h3F);

    // Second frame: digits 1,2,3,4,5,6; no further frame pulse until cycle 96.
    n_frames = 0;
    for (int k = 49; k < 96; k++) begin
      adv_to(k);
      if (frame_o) n_frames++;
      if (k == 50) begin
        check("s0_an", 8'(an_n), 8'h3E); check("s0_seg", 8'(seg_n), 8'h02);
      end
      if (k == 82) begin
        check("h0_an", 8'(an_n), 8'h2F); check("h0_seg", 8'(seg_n), 8'h24);
        check("h0_dp", 8'(dp_n), 8'h00);
      end
      if (k == 90) begin
        check("h1_an", 8'(an_n), 8'h1F); check("h1_seg", 8'(seg_n), 8'h79);
        check("h1_dp", 8'(dp_n), 8'h01);
      end
    end
    check("frame_gap", 8'(n_frames), 8'd0);
    adv_to(96); check("frame2", 8'(frame_o), 8'h01);

    // Hours tens goes to zero: visible only after the snapshot at 144.
    adv_to(100); h1_i = 4'd0;
    adv_to(138); check("h1_old_an", 8'(an_n), 8'h1F);
    adv_to(162); s0_i = 4'd9;
    adv_to(178); check("h0_unaff_an", 8'(an_n), 8'h2F);
    adv_to(186); check("lzb_an", 8'(an_n), 8'h3F); check("lzb_seg", 8'(seg_n), 8'h40);
    adv_to(191); check("lzb_end_an", 8'(an_n), 8'h3F); check("pre_f4", 8'(frame_o), 8'h00);
    adv_to(192); check("s0_new_seg", 8'(seg_n), 8'h10); check("frame4", 8'(frame_o), 8'h01);

    // Non-BCD code and alarm.
    adv_to(200); s0_i = 4'hA; alarm_i = 1'b1;
    adv_to(242); check("dash_seg", 8'(seg_n), 8'h3F);
`ifdef DISPLAY_BLINK_EN
    check("blink_off_an", 8'(an_n), 8'h3F);
    adv_to(258); check("blink_off_an2", 8'(an_n), 8'h3F); check("blink_off_dp", 8'(dp_n), 8'h01);
    adv_to(266); check("blink_on_an", 8'(an_n), 8'h37);
    adv_to(298); check("blink_off_an3", 8'(an_n), 8'h3F);
`else
    check("noblink_an", 8'(an_n), 8'h3E);
    adv_to(258); check("noblink_an2", 8'(an_n), 8'h3B); check("noblink_dp", 8'(dp_n), 8'h00);
    adv_to(266); check("noblink_an3", 8'(an_n), 8'h37);
    adv_to(298); check("noblink_an4", 8'(an_n), 8'h3D);
`endif
    adv_to(300); alarm_i = 1'b0;
    adv_to(301); check("alarm_drop_an", 8'(an_n), 8'h3D);

    // Asynchronous reset in the middle of slot 3.
    adv_to(314); check("mid3_an", 8'(an_n), 8'h37);
    #2 reset_reset_n = 1'b0;
    #1 check_reset_vals("rst_async");
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    cyc = 0;
    adv_to(2);  check("rr_an", 8'(an_n), 8'h3E); check("rr_seg", 8'(seg_n), 8'h7F);
    adv_to(8);  check("rr_tick_seg", 8'(seg_n), 8'h40);
    adv_to(10); check("rr_slot1_an", 8'(an_n), 8'h3D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
